// File: rtl/victim_cache_fa_pkg.sv
// Shared defaults, state codes and record types for the fully-associative victim cache.
package victim_cache_fa_pkg;

  localparam int VC_WAYS     = 8;
  localparam int VC_ADDR_W   = 32;
  localparam int VC_LINE_W   = 128;
  localparam int VC_OFFSET_W = 4;
  localparam int VC_TAG_W    = VC_ADDR_W - VC_OFFSET_W;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WB_WAIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WB_WAIT = 1'b1
  } vc_state_t;

  typedef logic [VC_LINE_W-1:0] cache_data_type;

  typedef struct packed {
    logic [VC_ADDR_W-1:0] addr;
    cache_data_type       data;
    logic                 dirty;
  } evict_data_type;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [VC_TAG_W-1:0] tag;
  } vc_entry_t;

endpackage

// File: rtl/vc_way_select.sv
// Insert target selection: equal tag, then swap into the lookup-hit way,
// then lowest invalid way, else the round-robin way (which displaces a line).
module vc_way_select
  import victim_cache_fa_pkg::*;
#(
  parameter int WAYS  = VC_WAYS,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  match,
  input  logic [WAYS-1:0]  hit,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] way,
  output logic             displace
);

  function automatic logic [IDX_W-1:0] lowest(input logic [WAYS-1:0] vec);
    lowest = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) lowest = IDX_W'(i);
    end
  endfunction

  always_comb begin
    way      = rr_ptr;
    displace = 1'b0;
    if (|match) begin
      way = lowest(match);
    end else if (|hit) begin
      way = lowest(hit);
    end else if (!(&valid)) begin
      way = lowest(~valid);
    end else begin
      displace = 1'b1;
    end
  end

endmodule

// File: rtl/victim_cache_fa.sv
// Fully-associative victim cache: swap-on-hit lookups, exclusive with L1, dirty
// victims written back to L2 over valid/ready. Optional counters: VC_STATS_EN.
module victim_cache_fa
  import victim_cache_fa_pkg::*;
#(
  parameter int WAYS     = VC_WAYS,
  parameter int ADDR_W   = VC_ADDR_W,
  parameter int LINE_W   = VC_LINE_W,
  parameter int OFFSET_W = VC_OFFSET_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ins_valid_i,
  input  logic [ADDR_W-1:0]          ins_addr_i,
  input  logic [LINE_W-1:0]          ins_data_i,
  input  logic                       ins_dirty_i,
  input  logic                       lkp_valid_i,
  input  logic [ADDR_W-1:0]          lkp_addr_i,
  output logic                       req_ready_o,
  output logic                       lkp_done_o,
  output logic                       lkp_hit_o,
  output logic [LINE_W-1:0]          lkp_data_o,
  output logic                       lkp_dirty_o,
  output logic                       wb_valid_o,
  output logic [ADDR_W-1:0]          wb_addr_o,
  output logic [LINE_W-1:0]          wb_data_o,
  input  logic                       wb_ready_i,
`ifdef VC_STATS_EN
  output logic [31:0]                stat_hits_o,
  output logic [31:0]                stat_misses_o,
  output logic [31:0]                stat_wbs_o,
  input  logic                       stat_clr_i,
`endif
  output logic [$clog2(WAYS+1)-1:0]  occupancy_o
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int IDX_W = $clog2(WAYS);
  localparam int OCC_W = $clog2(WAYS + 1);

  logic [0:0]       state;
  logic [WAYS-1:0]  valid, dirty, valid_next, dirty_next;
  logic [IDX_W-1:0] rr_ptr, way, hit_idx;
  logic [TAG_W-1:0] tag_mem  [WAYS];
  logic [LINE_W-1:0] data_mem [WAYS];

  logic [TAG_W-1:0] ins_tag, lkp_tag;
  logic [WAYS-1:0]  ins_match, lkp_match, hit_vec;
  logic             ins_fire, lkp_fire, lkp_hit, displace_raw, displace;
  logic             unused_offset;

  function automatic logic [OCC_W-1:0] occ_count(input logic [WAYS-1:0] v);
    occ_count = '0;
    for (int i = 0; i < WAYS; i++) occ_count = occ_count + OCC_W'(v[i]);
  endfunction

  assign req_ready_o   = !rst && (state == ST_IDLE);
  assign ins_fire      = ins_valid_i && req_ready_o;
  assign lkp_fire      = lkp_valid_i && req_ready_o;
  assign ins_tag       = ins_addr_i[ADDR_W-1:OFFSET_W];
  assign lkp_tag       = lkp_addr_i[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^{ins_addr_i[OFFSET_W-1:0], lkp_addr_i[OFFSET_W-1:0]};

  always_comb begin
    ins_match = '0;
    lkp_match = '0;
    for (int i = 0; i < WAYS; i++) begin
      ins_match[i] = valid[i] && (tag_mem[i] == ins_tag);
      lkp_match[i] = valid[i] && (tag_mem[i] == lkp_tag);
    end
  end

  assign hit_vec = lkp_fire ? lkp_match : '0;
  assign lkp_hit = |hit_vec;

  always_comb begin
    hit_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  vc_way_select #(
    .WAYS  (WAYS),
    .IDX_W (IDX_W)
  ) u_way_select (
    .valid    (valid),
    .match    (ins_match),
    .hit      (hit_vec),
    .rr_ptr   (rr_ptr),
    .way      (way),
    .displace (displace_raw)
  );

  assign displace = ins_fire && displace_raw;

  // Lookup sees pre-insert contents; the insert write is applied last so it wins
  always_comb begin
    valid_next = valid;
    dirty_next = dirty;
    if (lkp_hit) begin
      valid_next[hit_idx] = 1'b0;
      dirty_next[hit_idx] = 1'b0;
    end
    if (ins_fire) begin
      valid_next[way] = 1'b1;
      dirty_next[way] = ins_dirty_i | ((|ins_match) & dirty[way]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      valid       <= '0;
      dirty       <= '0;
      rr_ptr      <= '0;
      occupancy_o <= '0;
      lkp_done_o  <= 1'b0;
      lkp_hit_o   <= 1'b0;
      lkp_data_o  <= '0;
      lkp_dirty_o <= 1'b0;
      wb_valid_o  <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
    end else begin
      valid       <= valid_next;
      dirty       <= dirty_next;
      occupancy_o <= occ_count(valid_next);
      lkp_done_o  <= lkp_fire;
      lkp_hit_o   <= lkp_hit;
      lkp_data_o  <= lkp_hit ? data_mem[hit_idx] : '0;
      lkp_dirty_o <= lkp_hit & dirty[hit_idx];
      if (displace) begin
        rr_ptr <= (rr_ptr == IDX_W'(WAYS - 1)) ? '0 : rr_ptr + IDX_W'(1);
      end
      if (displace && dirty[rr_ptr]) begin
        wb_valid_o <= 1'b1;
        wb_addr_o  <= {tag_mem[rr_ptr], {OFFSET_W{1'b0}}};
        wb_data_o  <= data_mem[rr_ptr];
        state      <= ST_WB_WAIT;
      end else if (wb_valid_o && wb_ready_i) begin
        wb_valid_o <= 1'b0;
        state      <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ins_fire) begin
      tag_mem[way]  <= ins_tag;
      data_mem[way] <= ins_data_i;
    end
  end

`ifdef VC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits_o   <= '0;
      stat_misses_o <= '0;
      stat_wbs_o    <= '0;
    end else if (stat_clr_i) begin
      stat_hits_o   <= '0;
      stat_misses_o <= '0;
      stat_wbs_o    <= '0;
    end else begin
      if (lkp_hit && (stat_hits_o != 32'hFFFF_FFFF)) stat_hits_o <= stat_hits_o + 32'd1;
      if (lkp_fire && !lkp_hit && (stat_misses_o != 32'hFFFF_FFFF))
        stat_misses_o <= stat_misses_o + 32'd1;
      if (wb_valid_o && wb_ready_i && (stat_wbs_o != 32'hFFFF_FFFF)) stat_wbs_o <= stat_wbs_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_victim_cache_fa.sv
// Self-checking bench for victim_cache_fa: vector table, corner sequences and a random run against a model.
module tb_victim_cache_fa;

  localparam int WAYS = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         ins_valid_i, ins_dirty_i, lkp_valid_i, wb_ready_i;
  logic [31:0]  ins_addr_i, lkp_addr_i;
  logic [127:0] ins_data_i;
  logic         req_ready_o, lkp_done_o, lkp_hit_o, lkp_dirty_o, wb_valid_o;
  logic [127:0] lkp_data_o, wb_data_o;
  logic [31:0]  wb_addr_o;
  logic [3:0]   occupancy_o;

  int total = 0;
  int bad   = 0;

  victim_cache_fa #(.WAYS(8), .ADDR_W(32), .LINE_W(128), .OFFSET_W(4)) dut (
    .clk(clk), .rst(rst),
    .ins_valid_i(ins_valid_i), .ins_addr_i(ins_addr_i), .ins_data_i(ins_data_i),
    .ins_dirty_i(ins_dirty_i), .lkp_valid_i(lkp_valid_i), .lkp_addr_i(lkp_addr_i),
    .req_ready_o(req_ready_o), .lkp_done_o(lkp_done_o), .lkp_hit_o(lkp_hit_o),
    .lkp_data_o(lkp_data_o), .lkp_dirty_o(lkp_dirty_o), .wb_valid_o(wb_valid_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ins_v;
    logic [31:0] ins_addr;
    bit          ins_dirty;
    bit          lkp_v;
    logic [31:0] lkp_addr;
    bit          exp_hit;
    int          exp_src;
    bit          exp_dirty;
    int          exp_occ;
  } vec_t;

  vec_t tv[9];

  // reference model state
  bit           m_valid[WAYS];
  bit           m_dirty[WAYS];
  logic [27:0]  m_tag[WAYS];
  logic [127:0] m_data[WAYS];
  int           m_rr;
  bit           m_wbp;
  logic [31:0]  m_wb_addr;
  logic [127:0] m_wb_data;
  bit           e_done, e_hit, e_dirty;
  logic [127:0] e_data;

  function automatic logic [127:0] vdata(input int k);
    logic [31:0] w;
    w = 32'hA500_0000 + k;
    return {w, ~w, w ^ 32'h5A5A_0F0F, w + 32'h1111_1111};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [31:0] ia, input logic [127:0] id, input bit idr,
                       input bit lv, input logic [31:0] la);
    ins_valid_i = iv; ins_addr_i = ia; ins_data_i = id; ins_dirty_i = idr;
    lkp_valid_i = lv; lkp_addr_i = la;
  endtask

  task automatic idle();
    drive(0, 32'h0, 128'h0, 0, 0, 32'h0);
  endtask

  task automatic model_reset();
    for (int j = 0; j < WAYS; j++) begin
      m_valid[j] = 0; m_dirty[j] = 0;
    end
    m_rr = 0; m_wbp = 0;
  endtask

  task automatic do_reset();
    idle();
    wb_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    model_reset();
  endtask

  // Applies the cache rules to the inputs presented this cycle; e_* hold what the next edge must show
  task automatic model_step();
    int hj, ej, w;
    bit rdy, nd;
    logic [27:0] it, lt;
    rdy = !m_wbp;
    it = ins_addr_i[31:4];
    lt = lkp_addr_i[31:4];
    e_done = 0; e_hit = 0; e_dirty = 0; e_data = '0;
    hj = -1; ej = -1; w = -1; nd = 0;
    if (m_wbp && wb_ready_i) m_wbp = 0;
    if (!rdy) return;
    for (int j = 0; j < WAYS; j++) begin
      if (m_valid[j] && m_tag[j] == lt) hj = j;
      if (m_valid[j] && m_tag[j] == it) ej = j;
    end
    if (lkp_valid_i) begin
      e_done = 1;
      if (hj >= 0) begin
        e_hit = 1; e_data = m_data[hj]; e_dirty = m_dirty[hj];
      end
    end
    if (ins_valid_i) begin
      nd = ins_dirty_i;
      if (ej >= 0) begin
        w = ej; nd = nd | m_dirty[ej];
      end else if (e_hit) begin
        w = hj;
      end else begin
        for (int j = WAYS - 1; j >= 0; j--) if (!m_valid[j]) w = j;
        if (w < 0) begin
          w = m_rr;
          m_rr = (m_rr + 1) % WAYS;
          if (m_dirty[w]) begin
            m_wbp = 1; m_wb_addr = {m_tag[w], 4'h0}; m_wb_data = m_data[w];
          end
        end
      end
    end
    if (e_hit) begin
      m_valid[hj] = 0; m_dirty[hj] = 0;
    end
    if (w >= 0) begin
      m_valid[w] = 1; m_dirty[w] = nd; m_tag[w] = it; m_data[w] = ins_data_i;
    end
  endtask

  function automatic int m_occ();
    int n = 0;
    for (int j = 0; j < WAYS; j++) n += m_valid[j];
    return n;
  endfunction

  task automatic fill(input bit dirty0);
    for (int i = 0; i < WAYS; i++) begin
      drive(1, (32'h100 + i) << 4, vdata(100 + i), dirty0 && (i == 0), 0, 32'h0);
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    wb_ready_i = 1'b0;
    idle();
    #2;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_done", lkp_done_o, 0);
    chk("rst_hit", lkp_hit_o, 0);
    chk("rst_ldata", lkp_data_o, 0);
    chk("rst_ldirty", lkp_dirty_o, 0);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_wba", wb_addr_o, 0);
    chk("rst_wbd", wb_data_o, 0);
    chk("rst_occ", occupancy_o, 0);
    do_reset();
    chk("ready_after_rst", req_ready_o, 1);

    // ins_v addr dirty | lkp_v addr | hit src dirty occ
    tv[0] = '{1, 32'h0000_1230, 0, 0, 32'h0,         0, -1, 0, 1};
    tv[1] = '{0, 32'h0,         0, 1, 32'h0000_1234, 1,  0, 0, 0};
    tv[2] = '{0, 32'h0,         0, 1, 32'h0000_1234, 0, -1, 0, 0};
    tv[3] = '{1, 32'h0000_1000, 1, 0, 32'h0,         0, -1, 0, 1};
    tv[4] = '{1, 32'h0000_2000, 0, 1, 32'h0000_1000, 1,  3, 1, 1};
    tv[5] = '{0, 32'h0,         0, 1, 32'h0000_2004, 1,  4, 0, 0};
    tv[6] = '{1, 32'h0000_3000, 0, 0, 32'h0,         0, -1, 0, 1};
    tv[7] = '{1, 32'h0000_300C, 1, 0, 32'h0,         0, -1, 0, 1};
    tv[8] = '{0, 32'h0,         0, 1, 32'h0000_3008, 1,  7, 1, 0};
    for (int k = 0; k < 9; k++) begin
      drive(tv[k].ins_v, tv[k].ins_addr, vdata(k), tv[k].ins_dirty, tv[k].lkp_v, tv[k].lkp_addr);
      tick();
      idle();
      chk($sformatf("v%0d_done", k), lkp_done_o, tv[k].lkp_v);
      chk($sformatf("v%0d_occ", k), occupancy_o, tv[k].exp_occ);
      chk($sformatf("v%0d_wbv", k), wb_valid_o, 0);
      if (tv[k].lkp_v) begin
        chk($sformatf("v%0d_hit", k), lkp_hit_o, tv[k].exp_hit);
        chk($sformatf("v%0d_data", k), lkp_data_o, tv[k].exp_src >= 0 ? vdata(tv[k].exp_src) : 128'h0);
        chk($sformatf("v%0d_dirty", k), lkp_dirty_o, tv[k].exp_dirty);
      end
    end
    tick();
    chk("done_pulse_ends", lkp_done_o, 0);

    // full cache, clean victims: round-robin replaces way 0 then way 1
    do_reset();
    fill(0);
    chk("full_occ", occupancy_o, 8);
    drive(1, 32'h0000_2000, vdata(200), 0, 0, 32'h0);
    tick();
    drive(1, 32'h0000_2010, vdata(201), 0, 0, 32'h0);
    tick();
    idle();
    chk("clean_evict_wbv", wb_valid_o, 0);
    chk("clean_evict_occ", occupancy_o, 8);
    chk("clean_evict_rdy", req_ready_o, 1);
    drive(0, 32'h0, 128'h0, 0, 1, 32'h0000_1000);
    tick();
    chk("way0_gone", lkp_hit_o, 0);
    drive(0, 32'h0, 128'h0, 0, 1, 32'h0000_1010);
    tick();
    chk("way1_gone", lkp_hit_o, 0);
    drive(0, 32'h0, 128'h0, 0, 1, 32'h0000_1020);
    tick();
    chk("way2_kept", lkp_hit_o, 1);
    chk("way2_data", lkp_data_o, vdata(102));
    drive(0, 32'h0, 128'h0, 0, 1, 32'h0000_2000);
    tick();
    idle();
    chk("new_line_hit", lkp_hit_o, 1);
    chk("new_line_data", lkp_data_o, vdata(200));

    // dirty victim with a stalled L2
    do_reset();
    fill(1);
    drive(1, 32'h0000_4000, vdata(300), 0, 0, 32'h0);
    tick();
    drive(0, 32'h0, 128'h0, 0, 1, 32'h0000_1010);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wb_valid_c%0d", c), wb_valid_o, 1);
      chk($sformatf("wb_addr_c%0d", c), wb_addr_o, 32'h0000_1000);
      chk($sformatf("wb_data_c%0d", c), wb_data_o, vdata(100));
      chk($sformatf("wb_rdy_c%0d", c), req_ready_o, 0);
      if (c > 0) chk($sformatf("held_lkp_c%0d", c), lkp_done_o, 0);
      if (c < 2) tick();
    end
    wb_ready_i = 1'b1;
    #1;
    chk("wb_rdy_hs_cycle", req_ready_o, 0);
    tick();
    wb_ready_i = 1'b0;
    idle();
    chk("wb_after_hs", wb_valid_o, 0);
    chk("rdy_after_hs", req_ready_o, 1);
    chk("occ_after_hs", occupancy_o, 8);
    chk("no_lkp_during_wait", lkp_done_o, 0);

    // reset while waiting on L2
    fill(0);
    do_reset();
    fill(1);
    drive(1, 32'h0000_5000, vdata(400), 0, 0, 32'h0);
    tick();
    idle();
    chk("pre_rst_wbv", wb_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wbv", wb_valid_o, 0);
    chk("rst_mid_occ", occupancy_o, 0);
    chk("rst_mid_rdy", req_ready_o, 0);
    tick();
    rst = 1'b0;
    drive(0, 32'h0, 128'h0, 0, 1, 32'h0000_1010);
    tick();
    idle();
    chk("post_rst_done", lkp_done_o, 1);
    chk("post_rst_miss", lkp_hit_o, 0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!m_wbp) begin
        drive($urandom_range(0, 1), ($urandom_range(0, 11) << 4) | $urandom_range(0, 15),
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1),
              $urandom_range(0, 1), ($urandom_range(0, 11) << 4) | $urandom_range(0, 15));
      end
      wb_ready_i = ($urandom_range(0, 2) == 0);
      model_step();
      tick();
      chk("r_ready", req_ready_o, !m_wbp);
      chk("r_done", lkp_done_o, e_done);
      chk("r_hit", lkp_hit_o, e_hit);
      chk("r_data", lkp_data_o, e_data);
      chk("r_dirty", lkp_dirty_o, e_dirty);
      chk("r_wbv", wb_valid_o, m_wbp);
      if (m_wbp) begin
        chk("r_wba", wb_addr_o, m_wb_addr);
        chk("r_wbd", wb_data_o, m_wb_data);
      end
      chk("r_occ", occupancy_o, m_occ());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/victim_cache_fa.md
Name: victim_cache_fa

Overview:
Parametrised fully-associative victim cache between L1 and L2. It generalises the fixed 8-way victim cache to any way count, line width and address split. It holds lines evicted from L1 and serves L1 misses by swap; a hit removes the line, so the contents stay exclusive with L1. Dirty lines displaced from a full cache are written back to L2 over a valid/ready channel.

Parameters:
WAYS, 8, number of entries; must be >= 2
ADDR_W, 32, byte address width
LINE_W, 128, line data width in bits
OFFSET_W, 4, byte-offset bits per line; tag width TAG_W = ADDR_W-OFFSET_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
ins_valid_i  in  1  L1 eviction present
ins_addr_i  in  ADDR_W  evicted line address; low OFFSET_W bits ignored
ins_data_i  in  LINE_W  evicted line data
ins_dirty_i  in  1  evicted line dirty
lkp_valid_i  in  1  L1 miss lookup request
lkp_addr_i  in  ADDR_W  lookup address; low OFFSET_W bits ignored
req_ready_o  out  1  high in IDLE; accepts insert and/or lookup this cycle
lkp_done_o  out  1  one-cycle pulse with the lookup result
lkp_hit_o  out  1  lookup hit; valid only while lkp_done_o is high
lkp_data_o  out  LINE_W  hit line data
lkp_dirty_o  out  1  hit line dirty bit
wb_valid_o  out  1  dirty victim write-back to L2 pending
wb_addr_o  out  ADDR_W  write-back address; offset bits are zero
wb_data_o  out  LINE_W  write-back data
wb_ready_i  in  1  L2 accepts write-back
occupancy_o  out  $clog2(WAYS+1)  count of valid entries

Behaviour:
- Reset (async, immediate): all valid and dirty bits 0, rr_ptr=0, state IDLE. Outputs: req_ready_o=0 while rst is high, then 1; lkp_done_o=0, lkp_hit_o=0, lkp_data_o=0, lkp_dirty_o=0, wb_valid_o=0, wb_addr_o=0, wb_data_o=0, occupancy_o=0.
- Reset during WB_WAIT drops the pending write-back without handshake.
- States:
  - IDLE: req_ready_o=1.
  - WB_WAIT: req_ready_o=0; wb_* held stable. Return to IDLE on the edge where wb_valid_o && wb_ready_i.
- Lookup, accepted when lkp_valid_i && req_ready_o:
  - Tag compare against all valid entries, captured at the accept edge.
  - Result is registered: lkp_done_o is high exactly in the following cycle (latency 1).
  - On a hit, the entry is invalidated at the accept edge. The dirty bit is returned so L1 keeps it.
  - Miss: lkp_hit_o=0 and lkp_data_o=0.
- Insert, accepted when ins_valid_i && req_ready_o. Way selection, in priority order:
  1. The way holding an equal tag: overwrite; dirty = old dirty OR ins_dirty_i.
  2. Simultaneous lookup hit: the insert takes the hit way (swap); no displacement.
  3. Lowest-index invalid way.
  4. Cache full: way rr_ptr. rr_ptr then advances, wrapping WAYS-1 to 0.
- Displaced line from case 4:
  - Dirty: captured into the wb_* registers at the accept edge; wb_valid_o rises next cycle; go to WB_WAIT.
  - Clean: dropped silently.
- The new line is written at the accept edge in every case.
- A simultaneous lookup always sees the contents before the insert.
- occupancy_o is registered and updated at the same edge.
- An insert never blocks a lookup in the same cycle.
- A request presented while req_ready_o=0 is not accepted; the requester holds it.

Optional Feature:
VC_STATS_EN
- Defined: adds output ports stat_hits_o[31:0], stat_misses_o[31:0], stat_wbs_o[31:0] and input stat_clr_i.
  - Counters increment on lookup hit, lookup miss and completed write-back handshake.
  - Counters saturate at 32'hFFFF_FFFF.
  - Cleared by rst or stat_clr_i; clear takes priority over increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- cache_def package gains:
  - vc_entry_t: packed struct of valid, dirty and tag[TAG_W-1:0], parameterised via the VC constants.
  - vc_state_t enum: IDLE, WB_WAIT.
- Reuses cache_data_type, and evict_data_type for the insert bundle.
- One sub-module, vc_way_select (combinational): inputs are the valid vector, tag-match vector, lookup-hit one-hot and rr_ptr; outputs the target way index and a displace flag.

Test Plan:
1. Reset, then insert addr 0x0000_1230 clean, then look up 0x0000_1234 -> lkp_done_o 1 cycle later, lkp_hit_o=1, data matches, occupancy 1->0.
2. Fill all 8 ways clean, then insert a 9th line -> way 0 replaced, no wb_valid_o, rr_ptr=1, occupancy stays 8.
3. Fill 8 ways with way 0 dirty, then insert a 9th line, holding wb_ready_i=0 for 3 cycles -> wb_valid_o high with stable addr/data, req_ready_o=0 for 4 cycles, IDLE after handshake.
4. Same-cycle insert of 0x2000 and lookup of 0x1000 (present, dirty) -> hit with lkp_dirty_o=1, 0x2000 occupies the same way, occupancy unchanged, no write-back.
5. Insert 0x3000 clean, then insert 0x3000 dirty -> occupancy 1; later lookup returns the second data with lkp_dirty_o=1.
6. Assert rst mid-WB_WAIT -> wb_valid_o drops immediately, occupancy 0, and a subsequent lookup misses.
